// File: rtl/pump_pwm_driver.sv
// Soft-start PWM driver for a water pump: ramps duty toward a speed-derived target
// once per ramp interval and drops to a latched FAULT whenever the inlet runs dry.
module pump_pwm_driver #(
   parameter int PRESC_DIV    = 4,
   parameter int RAMP_PERIODS = 4,
   parameter int RAMP_STEP    = 17
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] pump_speed,
   input  logic       dry_run,
   output logic       pwm_out,
   output logic [7:0] duty,
   output logic       ramping,
   output logic       fault
);

   typedef enum logic [2:0] {
      IDLE,
      RAMP_UP,
      RAMP_DOWN,
      RUN,
      FAULT
   } state_t;

   localparam logic [15:0] PRESC_LAST = 16'(PRESC_DIV - 1);
   localparam logic [7:0]  RAMP_LAST  = 8'(RAMP_PERIODS - 1);
   localparam logic [8:0]  STEP       = 9'(RAMP_STEP);

   state_t      state;
   state_t      state_next;
   logic [15:0] presc;
   logic [7:0]  pwm_cnt;
   logic [7:0]  ramp_cnt;
   logic [7:0]  target;
   logic [7:0]  target_next;
   logic [7:0]  duty_next;
   logic [7:0]  speed_target;
   logic        tick;
   logic        period_end;
   logic        ramp_step;

   assign tick       = (presc == PRESC_LAST);
   assign period_end = tick && (pwm_cnt == 8'd255);
   assign ramp_step  = period_end && (ramp_cnt == RAMP_LAST);

   always_comb begin
      case (pump_speed)
         2'd0:    speed_target = 8'd0;
         2'd1:    speed_target = 8'd85;
         2'd2:    speed_target = 8'd170;
         default: speed_target = 8'd255;
      endcase
   end

   // Widened to 9 bits so the saturation test can never be fooled by an 8-bit wrap.
   function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
      logic [8:0] c9;
      logic [8:0] t9;
      c9 = {1'b0, cur};
      t9 = {1'b0, tgt};
      if (c9 < t9) begin
         return ((c9 + STEP) >= t9) ? tgt : cur + STEP[7:0];
      end else if (c9 > t9) begin
         return ((c9 - t9) <= STEP) ? tgt : cur - STEP[7:0];
      end else begin
         return cur;
      end
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         presc    <= '0;
         pwm_cnt  <= '0;
         ramp_cnt <= '0;
      end else begin
         presc <= tick ? '0 : presc + 16'd1;
         if (tick) begin
            pwm_cnt <= pwm_cnt + 8'd1;
         end
         if (period_end) begin
            ramp_cnt <= ramp_step ? '0 : ramp_cnt + 8'd1;
         end
      end
   end

   // State follows from where the new duty lands relative to the new target, which
   // also makes a mid-ramp reversal switch direction without an intermediate state.
   always_comb begin
      state_next  = state;
      target_next = target;
      duty_next   = duty;
      if (dry_run) begin
         state_next  = FAULT;
         target_next = 8'd0;
         duty_next   = 8'd0;
      end else if (state == FAULT) begin
         if (period_end && (pump_speed == 2'd0)) begin
            state_next = IDLE;
         end
      end else if (period_end) begin
         target_next = speed_target;
         if (ramp_step) begin
            duty_next = step_toward(duty, speed_target);
         end
         if (duty_next == target_next) begin
            state_next = (target_next == 8'd0) ? IDLE : RUN;
         end else if (duty_next < target_next) begin
            state_next = RAMP_UP;
         end else begin
            state_next = RAMP_DOWN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         target  <= '0;
         duty    <= '0;
         pwm_out <= 1'b0;
      end else begin
         state   <= state_next;
         target  <= target_next;
         duty    <= duty_next;
         pwm_out <= !dry_run && (pwm_cnt < duty);
      end
   end

   assign ramping = (state == RAMP_UP) || (state == RAMP_DOWN);
   assign fault   = (state == FAULT);

endmodule
